// File: rtl/iob_cpu_bus_arb_if.sv
// One IOb native bus: request fields flow master->slave; ready/rdata flow back.
// Ready is a single-cycle completion pulse; valid is held with stable fields until ready.
interface iob_cpu_bus_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  valid;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  ready;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output valid, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/iob_cpu_bus_arb.sv
// 2:1 instruction/data bus arbiter onto one IOb port, one outstanding txn, response timeout; IOB_ARB_DATA_PRIO_EN selects fixed m1 priority.
// Latency: 1 arbitration cycle + slave latency; masters are held by withholding ready, min 1 idle cycle between txns.
module iob_cpu_bus_arb #(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter int          TO_W     = 8,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              rst_n,
    iob_cpu_bus_arb_if.slave  m0,
    iob_cpu_bus_arb_if.slave  m1,
    iob_cpu_bus_arb_if.master s,
    output logic              grant,
    output logic              timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [DATA_W-1:0] ERR_D   = DATA_W'(ERR_DATA);
    // Counter value seen during the (2^TO_W-1)-th BUSY cycle, since it is cleared on entry.
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'((2 ** TO_W) - 2);

    state_t            state;
    state_t            state_nxt;
    logic              grant_nxt;
    logic              pick;
    logic              to_hit;
    logic [TO_W-1:0]   to_cnt;
    logic [DATA_W-1:0] rsp_dat;

`ifdef IOB_ARB_DATA_PRIO_EN
    always_comb begin
        pick = m1.valid;
    end
`else
    logic last_grant;

    always_comb begin
        if (m0.valid && m1.valid) begin
            pick = ~last_grant;
        end else begin
            pick = m1.valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && state_nxt == BUSY) begin
            last_grant <= grant_nxt;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        to_hit    = 1'b0;
        rsp_dat   = s.rdata;
        s.valid   = 1'b0;
        s.addr    = '0;
        s.wdata   = '0;
        s.wstrb   = '0;
        m0.ready  = 1'b0;
        m0.rdata  = '0;
        m1.ready  = 1'b0;
        m1.rdata  = '0;
        case (state)
            IDLE: begin
                if (m0.valid || m1.valid) begin
                    grant_nxt = pick;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // A real completion on the limit cycle wins over the timeout.
                to_hit  = !s.ready && (to_cnt == TO_LAST);
                if (to_hit) begin
                    rsp_dat = ERR_D;
                end
                s.valid = 1'b1;
                if (grant) begin
                    s.addr   = m1.addr;
                    s.wdata  = m1.wdata;
                    s.wstrb  = m1.wstrb;
                    m1.ready = s.ready || to_hit;
                    m1.rdata = rsp_dat;
                end else begin
                    s.addr   = m0.addr;
                    s.wdata  = m0.wdata;
                    s.wstrb  = m0.wstrb;
                    m0.ready = s.ready || to_hit;
                    m0.rdata = rsp_dat;
                end
                if (s.ready || to_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= 1'b0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (state == IDLE) begin
                to_cnt <= '0;
            end else if (!s.ready) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (to_hit) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule
